// File: rtl/sram_burst_master.sv
// Burst initiator for a single-port byte-enabled SRAM with combinational read data.
// Write beats stream straight to the SRAM; read beats land in a 2-entry credit-managed buffer.
module sram_burst_master #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 10,
  parameter int LENWIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDRWIDTH-1:0] cmd_addr,
  input  logic [LENWIDTH-1:0]  cmd_len,
  input  logic [3:0]           cmd_be,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [DATAWIDTH-1:0] wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [DATAWIDTH-1:0] rd_data,
  output logic                 rd_last,
  output logic                 busy,
  output logic                 sram_cs,
  output logic [3:0]           sram_we,
  output logic [ADDRWIDTH-1:0] sram_addr,
  output logic [DATAWIDTH-1:0] sram_wdata,
  input  logic [DATAWIDTH-1:0] sram_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t               state, state_nxt;
  logic [ADDRWIDTH-1:0] cur_addr;
  logic [LENWIDTH-1:0]  remain;
  logic [3:0]           be_r;
  logic [1:0]           credits;
  logic                 cap_pend, cap_last;
  logic [DATAWIDTH-1:0] buf_data [2];
  logic                 buf_last [2];
  logic                 wptr, rptr;
  logic [1:0]           count;

  logic cmd_fire, wr_fire, pop, rd_issue, beat, last_beat;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign wr_fire   = wr_valid & wr_ready;
  assign pop       = rd_valid & rd_ready;
  // A pop on this edge frees a slot that the same edge may already reuse.
  assign rd_issue  = (state == READ) && ((credits != 2'd0) || pop);
  assign beat      = wr_fire | rd_issue;
  assign last_beat = beat && (remain == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = cmd_write ? WRITE : READ;
      end
      WRITE: begin
        wr_ready = 1'b1;
        if (last_beat) state_nxt = IDLE;
      end
      READ: begin
        if (last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr   <= '0;
      remain     <= '0;
      be_r       <= '0;
      credits    <= 2'd2;
      cap_pend   <= 1'b0;
      cap_last   <= 1'b0;
      sram_cs    <= 1'b0;
      sram_we    <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      if (cmd_fire) begin
        cur_addr <= cmd_addr;
        remain   <= cmd_len;
        be_r     <= cmd_be;
      end else if (beat) begin
        cur_addr <= cur_addr + 1'b1;
        if (remain != '0) remain <= remain - 1'b1;
      end
      credits  <= credits + {1'b0, pop} - {1'b0, rd_issue};
      cap_pend <= rd_issue;
      if (rd_issue) cap_last <= (remain == '0);
      // Zero byte enables still consume write beats but never select the SRAM.
      sram_cs <= (wr_fire && (be_r != 4'd0)) || rd_issue;
      sram_we <= wr_fire ? be_r : 4'd0;
      if (beat)    sram_addr  <= cur_addr;
      if (wr_fire) sram_wdata <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (cap_pend) wptr <= ~wptr;
      if (pop)      rptr <= ~rptr;
      count <= count + {1'b0, cap_pend} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (cap_pend) begin
      buf_data[wptr] <= sram_rdata;
      buf_last[wptr] <= cap_last;
    end
  end

  assign rd_valid = (count != 2'd0);
  assign rd_data  = rd_valid ? buf_data[rptr] : '0;
  assign rd_last  = rd_valid & buf_last[rptr];
  assign busy     = (state != IDLE) || rd_valid;

endmodule

// File: tb/tb_sram_burst_master.sv
// Bench for sram_burst_master: behavioural SRAM, reference memory and scoreboards for
// SRAM write cycles and read-stream beats.
module tb_sram_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [9:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic [3:0]  cmd_be;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready, rd_last, busy;
  logic [31:0] rd_data;
  logic        sram_cs;
  logic [3:0]  sram_we;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  int checks = 0;
  int failures = 0;
  int rd_issue_cnt = 0;
  int cs_cnt = 0;
  int rd_hs_cnt = 0;

  logic [31:0] sram_mem [1024];
  logic [31:0] ref_mem  [1024];
  logic [45:0] wr_q [$];
  logic [32:0] rd_q [$];
  logic [31:0] wbuf [$];

  always #5 clk = ~clk;

  sram_burst_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_be(cmd_be),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  assign sram_rdata = sram_mem[sram_addr];

  always @(posedge clk) begin
    if (sram_cs && sram_we != 4'd0) begin
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
    end
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (sram_cs) begin
        cs_cnt++;
        if (sram_we == 4'd0) rd_issue_cnt++;
        else begin
          checks++;
          if (wr_q.size() == 0) begin
            failures++;
            $display("FAIL sram_write unexpected addr=%h data=%h we=%h", sram_addr, sram_wdata, sram_we);
          end else begin
            logic [45:0] e;
            e = wr_q.pop_front();
            if ({sram_addr, sram_wdata, sram_we} !== e) begin
              failures++;
              $display("FAIL sram_write got addr=%h data=%h we=%h expected addr=%h data=%h we=%h",
                       sram_addr, sram_wdata, sram_we, e[45:36], e[35:4], e[3:0]);
            end
          end
        end
      end
      if (rd_valid && rd_ready) begin
        rd_hs_cnt++;
        checks++;
        if (rd_q.size() == 0) begin
          failures++;
          $display("FAIL rd_beat unexpected data=%h last=%b", rd_data, rd_last);
        end else begin
          logic [32:0] e;
          e = rd_q.pop_front();
          if ({rd_last, rd_data} !== e) begin
            failures++;
            $display("FAIL rd_beat got data=%h last=%b expected data=%h last=%b",
                     rd_data, rd_last, e[31:0], e[32]);
          end
        end
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic send_cmd(input logic wr, input logic [9:0] addr, input int len, input logic [3:0] be);
    int k;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len[7:0]; cmd_be = be;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    if (k == 200) begin
      $display("FAIL cmd_handshake timeout");
      $fatal(1);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic push_writes(input logic [9:0] addr, input int len, input logic [3:0] be);
    for (int i = 0; i <= len; i++) begin
      logic [9:0] a;
      a = addr + 10'(i);
      ref_mem[a] = merge(ref_mem[a], wbuf[i], be);
      if (be != 4'd0) wr_q.push_back({a, wbuf[i], be});
    end
  endtask

  task automatic send_beat(input logic [31:0] d);
    int k;
    wr_valid = 1'b1; wr_data = d;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (wr_ready) break;
    end
    if (k == 200) begin
      $display("FAIL wr_handshake timeout");
      $fatal(1);
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic do_write(input logic [9:0] addr, input int len, input logic [3:0] be);
    push_writes(addr, len, be);
    send_cmd(1'b1, addr, len, be);
    for (int i = 0; i <= len; i++) send_beat(wbuf[i]);
  endtask

  task automatic do_read(input logic [9:0] addr, input int len);
    for (int i = 0; i <= len; i++) begin
      logic [9:0] a;
      a = addr + 10'(i);
      rd_q.push_back({(i == len), ref_mem[a]});
    end
    send_cmd(1'b0, addr, len, 4'd0);
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 500; k++) begin
      @(negedge clk);
      if (rd_q.size() == 0 && wr_q.size() == 0 && !busy) break;
    end
    checks++;
    if (k == 500) begin
      failures++;
      $display("FAIL %s drain timeout rd_q=%0d wr_q=%0d busy=%b", name, rd_q.size(), wr_q.size(), busy);
      rd_q.delete(); wr_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cmd_ready, wr_ready, rd_valid, rd_last, busy, sram_cs} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_ctrl got %b expected 100000",
               {cmd_ready, wr_ready, rd_valid, rd_last, busy, sram_cs});
    end
    checks++;
    if ({sram_we, sram_addr, sram_wdata, rd_data} !== 78'd0) begin
      failures++;
      $display("FAIL reset_data got we=%h addr=%h wdata=%h rdata=%h expected zeros",
               sram_we, sram_addr, sram_wdata, rd_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap;
    wbuf = '{32'h11, 32'h22, 32'h33, 32'h44};
    do_write(10'h3FE, 3, 4'hF);
    wait_idle("wrap_write");
    rd_q.push_back({1'b0, 32'h11}); rd_q.push_back({1'b0, 32'h22});
    rd_q.push_back({1'b0, 32'h33}); rd_q.push_back({1'b1, 32'h44});
    send_cmd(1'b0, 10'h3FE, 3, 4'd0);
    wait_idle("wrap_read");
  endtask

  task automatic test_byte_enable;
    wbuf = '{32'hAABBCCDD};
    do_write(10'd5, 0, 4'hF);
    wait_idle("be_full");
    wbuf = '{32'h11223344};
    do_write(10'd5, 0, 4'h5);
    wait_idle("be_partial");
    rd_q.push_back({1'b1, 32'hAA22CC44});
    send_cmd(1'b0, 10'd5, 0, 4'd0);
    wait_idle("be_read");
  endtask

  task automatic test_read_backpressure;
    logic [31:0] held;
    rd_ready = 1'b0;
    rd_issue_cnt = 0;
    do_read(10'h100, 7);
    repeat (3) @(posedge clk);
    #1 held = rd_data;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (rd_issue_cnt !== 2) begin
      failures++;
      $display("FAIL stall_reads got %0d expected 2", rd_issue_cnt);
    end
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== held || held !== ref_mem[10'h100]) begin
      failures++;
      $display("FAIL stall_hold got valid=%b data=%h held=%h expected valid=1 data=%h",
               rd_valid, rd_data, held, ref_mem[10'h100]);
    end
    rd_ready = 1'b1;
    wait_idle("stall_drain");
  endtask

  task automatic test_write_gaps;
    wbuf = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    push_writes(10'h40, 3, 4'hF);
    send_cmd(1'b1, 10'h40, 3, 4'hF);
    for (int i = 0; i <= 3; i++) begin
      send_beat(wbuf[i]);
      checks++;
      if (sram_cs !== 1'b1 || sram_addr !== 10'(10'h40 + i) || cmd_ready !== (i == 3)) begin
        failures++;
        $display("FAIL gap_beat%0d got cs=%b addr=%h cmd_ready=%b expected cs=1 addr=%h cmd_ready=%b",
                 i, sram_cs, sram_addr, cmd_ready, 10'(10'h40 + i), (i == 3));
      end
      if (i < 3) begin
        repeat (2) begin
          @(posedge clk); #1;
          checks++;
          if (sram_cs !== 1'b0) begin
            failures++;
            $display("FAIL gap_idle got cs=%b expected 0", sram_cs);
          end
        end
      end
    end
    wait_idle("gap_write");
  endtask

  task automatic test_stream_and_zero_be;
    int n;
    rd_ready = 1'b1;
    do_read(10'h200, 15);
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_t0 got rd_valid=%b expected 0", rd_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_t1 got rd_valid=%b expected 0", rd_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL stream_t2 got rd_valid=%b expected 1", rd_valid);
    end
    n = (rd_valid === 1'b1) ? 1 : 0;
    for (int k = 0; k < 40 && n > 0; k++) begin
      @(posedge clk); #1;
      if (rd_valid) n++;
      else break;
    end
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL stream_run got %0d expected 16", n);
    end
    wait_idle("stream");
    cs_cnt = 0;
    wbuf = '{32'hDEAD0001, 32'hDEAD0002};
    do_write(10'h300, 1, 4'h0);
    wait_idle("zero_be");
    checks++;
    if (cs_cnt !== 0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_be got cs_cycles=%0d cmd_ready=%b expected 0 and 1", cs_cnt, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_burst;
    int k;
    rd_ready = 1'b1;
    rd_hs_cnt = 0;
    do_read(10'h080, 7);
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rd_hs_cnt >= 3) break;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    rd_q.delete();
    checks++;
    if ({rd_valid, sram_cs, busy, cmd_ready} !== 4'b0001 || k == 100) begin
      failures++;
      $display("FAIL mid_reset got valid=%b cs=%b busy=%b cmd_ready=%b expected 0 0 0 1",
               rd_valid, sram_cs, busy, cmd_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    cs_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cs_cnt !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_quiet got cs_cycles=%0d busy=%b expected 0 0", cs_cnt, busy);
    end
    wbuf = '{32'h5A5A0001, 32'h5A5A0002};
    do_write(10'h020, 1, 4'hF);
    wait_idle("post_reset_write");
    do_read(10'h020, 1);
    wait_idle("post_reset_read");
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i] = 32'hC0DE0000 | i;
      ref_mem[i]  = 32'hC0DE0000 | i;
    end
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_be = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
    test_reset;
    test_wrap;
    test_byte_enable;
    test_read_backpressure;
    test_write_gaps;
    test_stream_and_zero_be;
    test_reset_mid_burst;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
